// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the parametrised linear sequencer.
//   seq_sw()      : width of the binary state index for N states (minimum 1)
//   MAX_STATES    : largest supported state count
//   step_e        : kind of step the sequencer takes on an edge
//   loop_word_t   : carrier type for the saturating wrap counter helper
package fsm_seq_pkg;

  localparam int MAX_STATES = 256;

  function automatic int seq_sw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Step chosen for the coming edge; lets a checker see why the index moved.
  typedef enum logic [2:0] {
    STEP_HOLD    = 3'd0,
    STEP_ADV     = 3'd1,
    STEP_WRAP    = 3'd2,
    STEP_TERM    = 3'd3,
    STEP_ABORT   = 3'd4,
    STEP_RECOVER = 3'd5
  } step_e;

  typedef logic [31:0] loop_word_t;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic loop_word_t sat_inc(input loop_word_t v, input int w);
    loop_word_t max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/fsm_onehot_dec.sv
// Binary index to one-hot decoder.
//   idx    in  SW  binary index
//   onehot out N   onehot[i]=1 when idx==i; all zero when idx >= N
module fsm_onehot_dec #(
  parameter int N  = 16,
  parameter int SW = 4
) (
  input  logic [SW-1:0] idx,
  output logic [N-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == SW'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/fsm_seq_param.sv
// Parametrised linear sequencer: NSTATES states advanced one per accepted
// strobe, with global hold, synchronous abort, wrap or terminal end mode,
// saturating wrap counter and registered entry/wrap pulses.
//   clk, rst    : clock, synchronous active-high reset
//   en          : 1 allows transitions, 0 freezes state (abort still acts)
//   abort       : return to state 0, clear done and loop_cnt
//   t[NSTATES]  : t[i] advances the sequencer only while in state i
//   st          : one-hot current state (all zero for an illegal index)
//   st_idx      : binary current state (also the FSM state for observation)
//   enter       : first cycle of a newly entered state
//   wrap_pulse  : first cycle of state 0 after a last->0 wrap
//   loop_cnt    : completed wraps, saturating
//   done        : sticky terminal flag, only when WRAP=0
// Handshake: none; t is a level-sampled strobe, one step per cycle at most.
module fsm_seq_param
  import fsm_seq_pkg::*;
#(
  parameter int NSTATES = 16,
  parameter int WRAP    = 1,
  parameter int LOOPS_W = 8,
  localparam int SW     = seq_sw(NSTATES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               abort,
  input  logic [NSTATES-1:0] t,
  output logic [NSTATES-1:0] st,
  output logic [SW-1:0]      st_idx,
  output logic               enter,
  output logic               wrap_pulse,
  output logic [LOOPS_W-1:0] loop_cnt,
  output logic               done
);

  localparam int            TW   = 1 << SW;
  localparam logic [SW-1:0] LAST = SW'(NSTATES - 1);
  localparam logic [SW:0]   NST  = (SW + 1)'(NSTATES);

  logic [SW-1:0]      idx_q, idx_d;
  logic               enter_q, enter_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic [LOOPS_W-1:0] loop_q, loop_d;
  step_e              step;

  // Padded strobe vector so the select by the index is always in range;
  // codes at or above NSTATES read a zero strobe.
  logic [TW-1:0] t_ext;
  logic          t_cur;
  logic          cur_legal;

  assign t_ext     = TW'(t);
  assign t_cur     = t_ext[idx_q];
  assign cur_legal = ({1'b0, idx_q} < NST);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      enter_q <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      loop_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      enter_q <= enter_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      loop_q  <= loop_d;
    end
  end

  always_comb begin
    step = STEP_HOLD;
    if (abort) begin
      step = STEP_ABORT;
    end else if (!cur_legal) begin
      // An out-of-range code recovers to 0 without needing en or a strobe.
      step = STEP_RECOVER;
    end else if (en && t_cur) begin
      if (idx_q == LAST) step = (WRAP != 0) ? STEP_WRAP : STEP_TERM;
      else               step = STEP_ADV;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    enter_d = 1'b0;
    wrap_d  = 1'b0;
    done_d  = done_q;
    loop_d  = loop_q;
    case (step)
      STEP_ADV: begin
        idx_d   = idx_q + SW'(1);
        enter_d = 1'b1;
      end
      STEP_WRAP: begin
        idx_d   = '0;
        enter_d = 1'b1;
        wrap_d  = 1'b1;
        loop_d  = LOOPS_W'(sat_inc(loop_word_t'(loop_q), LOOPS_W));
      end
      STEP_TERM: begin
        // Terminal state: no state change, so no entry pulse.
        done_d = 1'b1;
      end
      STEP_ABORT: begin
        idx_d   = '0;
        enter_d = 1'b1;
        done_d  = 1'b0;
        loop_d  = '0;
      end
      STEP_RECOVER: begin
        idx_d   = '0;
        enter_d = 1'b1;
      end
      default: ;
    endcase
  end

  fsm_onehot_dec #(
    .N  (NSTATES),
    .SW (SW)
  ) u_dec (
    .idx    (idx_q),
    .onehot (st)
  );

  assign st_idx     = idx_q;
  assign enter      = enter_q;
  assign wrap_pulse = wrap_q;
  assign loop_cnt   = loop_q;
  assign done       = (WRAP != 0) ? 1'b0 : done_q;

endmodule

// File: tb/tb_fsm_seq_param.sv
module tb_fsm_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        abort;
  logic [15:0] t_a;
  logic        en_c;
  logic        abort_c;
  logic [4:0]  t_c;

  logic [15:0] st_a, st_b;
  logic [3:0]  idx_a, idx_b;
  logic        enter_a, enter_b, wrap_a, wrap_b, done_a, done_b;
  logic [7:0]  loop_a, loop_b;

  logic [4:0]  st_c;
  logic [2:0]  idx_c;
  logic        enter_c, wrap_c, done_c;
  logic [1:0]  loop_c;

  int total = 0;
  int bad   = 0;

  // Reference state: [0] = wrapping 16-state unit, [1] = terminal 16-state unit.
  int m_cur[2];
  int m_loops[2];
  bit m_done[2];
  bit m_enter[2];
  bit m_wrap[2];

  always #5 clk = ~clk;

  fsm_seq_param #(.NSTATES(16), .WRAP(1), .LOOPS_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .abort(abort), .t(t_a),
    .st(st_a), .st_idx(idx_a), .enter(enter_a), .wrap_pulse(wrap_a),
    .loop_cnt(loop_a), .done(done_a)
  );

  fsm_seq_param #(.NSTATES(16), .WRAP(0), .LOOPS_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .abort(abort), .t(t_a),
    .st(st_b), .st_idx(idx_b), .enter(enter_b), .wrap_pulse(wrap_b),
    .loop_cnt(loop_b), .done(done_b)
  );

  fsm_seq_param #(.NSTATES(5), .WRAP(1), .LOOPS_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .abort(abort_c), .t(t_c),
    .st(st_c), .st_idx(idx_c), .enter(enter_c), .wrap_pulse(wrap_c),
    .loop_cnt(loop_c), .done(done_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sequencer rules applied to the current inputs, for one edge.
  task automatic model_step(input int k, input bit wrap_mode);
    if (rst) begin
      m_cur[k] = 0; m_loops[k] = 0; m_done[k] = 0; m_enter[k] = 0; m_wrap[k] = 0;
    end else if (abort) begin
      m_cur[k] = 0; m_loops[k] = 0; m_done[k] = 0; m_enter[k] = 1; m_wrap[k] = 0;
    end else if (en && t_a[m_cur[k]]) begin
      if (m_cur[k] == 15) begin
        if (wrap_mode) begin
          m_cur[k] = 0; m_enter[k] = 1; m_wrap[k] = 1;
          if (m_loops[k] < 255) m_loops[k]++;
        end else begin
          m_done[k] = 1; m_enter[k] = 0; m_wrap[k] = 0;
        end
      end else begin
        m_cur[k]++; m_enter[k] = 1; m_wrap[k] = 0;
      end
    end else begin
      m_enter[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic check_models(input string tag);
    chk({tag, "_a_st"},    32'(st_a),    32'(1) << m_cur[0]);
    chk({tag, "_a_idx"},   32'(idx_a),   32'(m_cur[0]));
    chk({tag, "_a_enter"}, 32'(enter_a), 32'(m_enter[0]));
    chk({tag, "_a_wrap"},  32'(wrap_a),  32'(m_wrap[0]));
    chk({tag, "_a_loop"},  32'(loop_a),  32'(m_loops[0]));
    chk({tag, "_a_done"},  32'(done_a),  32'(0));
    chk({tag, "_b_st"},    32'(st_b),    32'(1) << m_cur[1]);
    chk({tag, "_b_idx"},   32'(idx_b),   32'(m_cur[1]));
    chk({tag, "_b_enter"}, 32'(enter_b), 32'(m_enter[1]));
    chk({tag, "_b_wrap"},  32'(wrap_b),  32'(0));
    chk({tag, "_b_loop"},  32'(loop_b),  32'(0));
    chk({tag, "_b_done"},  32'(done_b),  32'(m_done[1]));
  endtask

  // One edge for the 16-state units: predict, clock, sample 1 after the edge.
  task automatic step_ab(input string tag);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(posedge clk);
    #1;
    check_models(tag);
  endtask

  task automatic pulse(input int k);
    t_a = '0;
    t_a[k] = 1'b1;
  endtask

  task automatic step_c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; abort = 1'b0; t_a = '0;
    en_c = 1'b0; abort_c = 1'b0; t_c = '0;
    #1;
    step_ab("rst0");
    step_ab("rst1");
    chk("rst_idx", 32'(idx_a), 32'd0);
    chk("rst_st", 32'(st_a), 32'd1);
    chk("rst_c_st", 32'(st_c), 32'd1);
    chk("rst_c_loop", 32'(loop_c), 32'd0);
    rst = 1'b0;

    // Walk all 16 states and wrap once.
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pulse(i);
      step_ab("walk");
      chk("walk_idx", 32'(idx_a), 32'((i + 1) % 16));
      chk("walk_enter", 32'(enter_a), 32'd1);
      chk("walk_wrap", 32'(wrap_a), 32'(i == 15));
    end
    chk("walk_loop", 32'(loop_a), 32'd1);
    chk("term_idx", 32'(idx_b), 32'd15);
    chk("term_done", 32'(done_b), 32'd1);

    // Abort clears done on the terminal unit and enters state 0.
    t_a = '0; abort = 1'b1;
    step_ab("abort1");
    chk("abort_b_done", 32'(done_b), 32'd0);
    chk("abort_a_enter0", 32'(enter_a), 32'd1);
    abort = 1'b0;

    // Reach state 3, then strobes for other states are ignored.
    for (int i = 0; i < 3; i++) begin
      pulse(i);
      step_ab("to3");
    end
    t_a = 16'h0021;
    step_ab("foreign");
    chk("foreign_idx", 32'(idx_a), 32'd3);
    chk("foreign_enter", 32'(enter_a), 32'd0);
    pulse(3); en = 1'b0;
    step_ab("frozen");
    chk("frozen_idx", 32'(idx_a), 32'd3);
    en = 1'b1;
    step_ab("thaw");
    chk("thaw_idx", 32'(idx_a), 32'd4);

    // Run to the end; terminal unit stays at 15 with done held.
    for (int i = 4; i < 16; i++) begin
      pulse(i);
      step_ab("run15");
    end
    pulse(15);
    step_ab("sticky");
    chk("sticky_done", 32'(done_b), 32'd1);
    chk("sticky_b_enter", 32'(enter_b), 32'd0);

    // Same-cycle abort and last strobe.
    for (int i = 0; i < 15; i++) begin
      pulse(i);
      step_ab("to15");
    end
    pulse(15); abort = 1'b1;
    step_ab("abort_last");
    chk("abort_last_idx", 32'(idx_a), 32'd0);
    chk("abort_last_wrap", 32'(wrap_a), 32'd0);
    chk("abort_last_loop", 32'(loop_a), 32'd0);
    abort = 1'b0;

    // Reset in state 7.
    for (int i = 0; i < 7; i++) begin
      pulse(i);
      step_ab("to7");
    end
    chk("pre_rst_idx", 32'(idx_a), 32'd7);
    rst = 1'b1; pulse(7);
    step_ab("mid_rst");
    chk("mid_rst_idx", 32'(idx_a), 32'd0);
    chk("mid_rst_enter", 32'(enter_a), 32'd0);
    rst = 1'b0;

    // Randomised traffic against the reference.
    for (int n = 0; n < 600; n++) begin
      en    = ($urandom_range(0, 9) < 8);
      abort = ($urandom_range(0, 39) == 0);
      t_a   = 16'($urandom) | 16'($urandom);
      step_ab("rand");
    end
    en = 1'b0; abort = 1'b0; t_a = '0;

    // Saturating 2-bit wrap counter on the 5-state unit.
    en_c = 1'b1; t_c = 5'h1f;
    for (int w = 1; w <= 5; w++) begin
      repeat (5) step_c();
      chk("sat_idx", 32'(idx_c), 32'd0);
      chk("sat_wrap", 32'(wrap_c), 32'd1);
      chk("sat_loop", 32'(loop_c), 32'((w > 3) ? 3 : w));
    end
    chk("sat_done", 32'(done_c), 32'd0);
    en_c = 1'b0; abort_c = 1'b1;
    step_c();
    chk("sat_abort_loop", 32'(loop_c), 32'd0);
    chk("sat_abort_enter", 32'(enter_c), 32'd1);
    abort_c = 1'b0; t_c = '0;
    step_c();

    // Illegal index on the 5-state unit recovers to 0 without en.
    dut_c.idx_q = 3'd6;
    #1;
    chk("illegal_st", 32'(st_c), 32'd0);
    chk("illegal_idx", 32'(idx_c), 32'd6);
    step_c();
    chk("recover_idx", 32'(idx_c), 32'd0);
    chk("recover_st", 32'(st_c), 32'd1);
    chk("recover_enter", 32'(enter_c), 32'd1);
    chk("recover_loop", 32'(loop_c), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
